resp_packer: RTL and testbench
==============================

RESP_PACKER -- requirements
Module: resp_packer

Interface
REQ-001 SHALL have parameter HDR_NIBBLE, default 4'hA: the value sent as the first beat of every response frame.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port data_in  input  42  readback word from sreg_ctrl data_out.
REQ-005 SHALL have port dvalid_in  input  1  one-cycle strobe from sreg_ctrl dvalid_out; data_in is valid in that cycle.
REQ-006 SHALL have port tx_data  output  4  outbound nibble toward the UART transmit path.
REQ-007 SHALL have port tx_valid  output  1  tx_data holds a valid beat.
REQ-008 SHALL have port tx_ready  input  1  downstream accepts a beat; a beat transfers when tx_valid and tx_ready are both 1 at a rising edge.
REQ-009 SHALL have port busy  output  1  a frame is held or in transmission.
REQ-010 SHALL have port drop_cnt  output  8  count of readback words lost while busy.

Function
REQ-011 SHALL implement FSM states IDLE, HEADER, DATA.
REQ-012 In IDLE, dvalid_in=1 SHALL capture data_in into an internal 42-bit register and move to HEADER at the same edge.
REQ-013 In HEADER, tx_valid SHALL be 1 with tx_data=HDR_NIBBLE; a transfer SHALL move to DATA with beat index 0.
REQ-014 A frame in DATA SHALL be 11 beats, MSB first: beat 0 = {2'b00, word[41:40]}, beat k (1..10) = word[43-4k : 40-4k], beat 10 = word[3:0].
REQ-015 The beat index SHALL be a 4-bit counter, 0..10; it SHALL advance only on a transfer.
REQ-016 Total frame length SHALL be 12 beats; with tx_ready held at 1, the frame SHALL occupy 12 consecutive cycles starting the cycle after dvalid_in.
REQ-017 tx_data and tx_valid SHALL stay stable while tx_valid=1 and tx_ready=0; tx_valid SHALL not drop until the beat transfers.
REQ-018 A transfer of beat 10 SHALL return the FSM to IDLE with tx_valid=0 in the next cycle, except as in REQ-019.
REQ-019 dvalid_in=1 in the same cycle as the beat-10 transfer SHALL capture the new word and move directly to HEADER (back-to-back frames, no idle gap).
REQ-020 dvalid_in=1 in HEADER or DATA (other than REQ-019) SHALL leave the held word unchanged and SHALL increment drop_cnt.
REQ-021 drop_cnt SHALL saturate at 8'hFF.
REQ-022 busy SHALL be 1 in HEADER and DATA and 0 in IDLE; it SHALL be registered, not derived from dvalid_in.
REQ-023 tx_data SHALL be 4'h0 whenever tx_valid=0.
REQ-024 tx_ready SHALL be ignored in IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, beat index 0, held word 0, tx_valid=0, tx_data=4'h0, busy=0, drop_cnt=8'h00.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further beats; after release, the block SHALL wait for a new dvalid_in.
REQ-027 A dvalid_in coinciding with the first edge after reset release SHALL be captured normally.

Verification
REQ-028 Single frame: data_in=42'h2A5_5A5A_5A5A with dvalid_in pulse, tx_ready=1 -> beats A,2,A,5,5,A,5,A,5,A,5,A on 12 consecutive cycles; busy=0 afterward.
REQ-029 Backpressure: same word, tx_ready toggling 1,0,0,1,... -> identical beat sequence; no beat repeats or skips; tx_data stable while stalled.
REQ-030 Back-to-back: second dvalid_in with word 42'h3FF_FFFF_FFFF in the beat-10 transfer cycle -> header A follows on the next cycle, then 3,F,F,F,F,F,F,F,F,F,F; drop_cnt=0.
REQ-031 Drop: dvalid_in pulsed 3 times during a frame -> the original frame completes unchanged; drop_cnt=3.
REQ-032 Saturation: 300 dvalid_in pulses with tx_ready=0 after the first capture -> drop_cnt=8'hFF, tx_data held at header A.
REQ-033 Reset mid-frame: rst_n low after beat 4 -> tx_valid=0, busy=0, drop_cnt=0 at once; a new word after release sends a full 12-beat frame.

Source files
------------

// File: rtl/resp_packer.sv
// Packs a 42-bit readback word into a 12-nibble response frame (header + 11 data beats)
// and streams it over a valid/ready nibble interface; words arriving mid-frame are counted as drops.
module resp_packer #(
    parameter logic [3:0] HDR_NIBBLE = 4'hA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [41:0] data_in,
    input  logic        dvalid_in,
    output logic [3:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned WORD_W = 42;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 8;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(10);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   word;
    logic [IDX_W-1:0]    beat_idx;
    logic                last_xfer;
    logic                drop_hit;

    // Beat k of the word, MSB first, with the word zero-extended to 44 bits.
    function automatic logic [NIB_W-1:0] beat_nibble(input logic [WORD_W-1:0] w,
                                                     input logic [IDX_W-1:0]  idx);
        logic [WORD_W+1:0] padded;
        logic [5:0]        shift;
        padded = {2'b00, w};
        shift  = 6'd40 - {idx, 2'b00};
        return NIB_W'(padded >> shift);
    endfunction

    // tx_valid is always high outside IDLE, so a transfer there is just tx_ready.
    assign last_xfer = (state == DATA) && tx_ready && (beat_idx == LAST_BEAT);
    assign drop_hit  = dvalid_in && (state != IDLE) && !last_xfer;

    // Frame sequencer with registered beat output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            word     <= '0;
            beat_idx <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dvalid_in) begin
                        word     <= data_in;
                        beat_idx <= '0;
                        tx_data  <= HDR_NIBBLE;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= HEADER;
                    end
                end
                HEADER: begin
                    if (tx_ready) begin
                        beat_idx <= '0;
                        tx_data  <= beat_nibble(word, '0);
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (tx_ready) begin
                        if (beat_idx == LAST_BEAT) begin
                            beat_idx <= '0;
                            if (dvalid_in) begin
                                word    <= data_in;
                                tx_data <= HDR_NIBBLE;
                                state   <= HEADER;
                            end else begin
                                tx_data  <= '0;
                                tx_valid <= 1'b0;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            beat_idx <= beat_idx + IDX_W'(1);
                            tx_data  <= beat_nibble(word, beat_idx + IDX_W'(1));
                        end
                    end
                end
                default: begin
                    beat_idx <= '0;
                    tx_data  <= '0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of words that arrived while a frame was outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_hit && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_resp_packer.sv
// Scoreboard bench for resp_packer: expected frames are queued at capture and popped on each transfer.
module tb_resp_packer;

    localparam logic [3:0] HDR = 4'hA;

    logic        clk;
    logic        rst_n;
    logic [41:0] data_in;
    logic        dvalid_in;
    logic [3:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  drop_cnt;

    int tests;
    int fails;
    logic [3:0] exp_q[$];

    resp_packer #(.HDR_NIBBLE(HDR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .dvalid_in (dvalid_in),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame: header, then the zero-extended word shifted out a nibble at a time.
    task automatic push_frame(input logic [41:0] w);
        logic [43:0] sh;
        sh = {2'b00, w};
        exp_q.push_back(HDR);
        for (int k = 0; k < 11; k++) begin
            exp_q.push_back(sh[43:40]);
            sh = sh << 4;
        end
    endtask

    // One-cycle dvalid_in pulse; entered and left at posedge+1.
    task automatic pulse(input logic [41:0] w, input bit captured);
        data_in   = w;
        dvalid_in = 1'b1;
        if (captured) push_frame(w);
        @(posedge clk); #1;
        dvalid_in = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy && !tx_valid) break;
            @(posedge clk); #1;
        end
        tests++;
        if (i == budget) begin
            fails++;
            $display("FAIL %s timeout: queue=%0d busy=%0b required queue=0 busy=0", name, exp_q.size(), busy);
        end
    endtask

    // Checks every transfer against the scoreboard, plus stall stability and idle-zero data.
    task automatic monitor_beats();
        logic       prev_stall;
        logic [3:0] prev_data;
        logic [3:0] exp;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    tests++;
                    if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                        fails++;
                        $display("FAIL stall_stable: valid=%0b data=%h required valid=1 data=%h", tx_valid, tx_data, prev_data);
                    end
                end
                if (tx_valid === 1'b0) begin
                    tests++;
                    if (tx_data !== 4'h0) begin
                        fails++;
                        $display("FAIL idle_data: data=%h required 0", tx_data);
                    end
                end
                if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL extra_beat: data=%h required no beat", tx_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if (tx_data !== exp) begin
                            fails++;
                            $display("FAIL beat: data=%h required %h", tx_data, exp);
                        end
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dvalid_in = 1'b0; tx_ready = 1'b0; data_in = '0;
        #2;
        tests++;
        if (tx_valid !== 1'b0 || tx_data !== 4'h0 || busy !== 1'b0 || drop_cnt !== 8'h00) begin
            fails++;
            $display("FAIL reset: valid=%0b data=%h busy=%0b drop=%h required 0/0/0/00", tx_valid, tx_data, busy, drop_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_ready_ignored: valid=%0b busy=%0b required 0/0", tx_valid, busy);
        end
    endtask

    task automatic test_single();
        tx_ready = 1'b1;
        pulse(42'h2A5_5A5A_5A5A, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests++;
            if (tx_valid !== 1'b1 || busy !== 1'b1) begin
                fails++;
                $display("FAIL single_cycle%0d: valid=%0b busy=%0b required 1/1", i, tx_valid, busy);
            end
        end
        @(negedge clk);
        tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL single_end: valid=%0b busy=%0b left=%0d required 0/0/0", tx_valid, busy, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        tx_ready = 1'b1;
        pulse(42'h2A5_5A5A_5A5A, 1'b1);
        cyc = 1;
        while (cyc < 200 && (exp_q.size() != 0 || busy)) begin
            tx_ready = (cyc % 3 == 0);
            @(posedge clk); #1;
            cyc++;
        end
        tx_ready = 1'b1;
        wait_idle("backpressure", 5);
    endtask

    task automatic test_back_to_back();
        tx_ready = 1'b1;
        pulse(42'h2A5_5A5A_5A5A, 1'b1);
        repeat (11) @(posedge clk);
        #1;
        pulse(42'h3FF_FFFF_FFFF, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests++;
            if (tx_valid !== 1'b1 || (i == 0 && tx_data !== HDR)) begin
                fails++;
                $display("FAIL b2b_cycle%0d: valid=%0b data=%h required valid=1", i, tx_valid, tx_data);
            end
        end
        @(posedge clk); #1;
        wait_idle("b2b", 20);
        tests++;
        if (drop_cnt !== 8'h00) begin
            fails++;
            $display("FAIL b2b_drop: drop=%h required 00", drop_cnt);
        end
    endtask

    task automatic test_drop();
        tx_ready = 1'b1;
        pulse(42'h123_4567_89AB, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            pulse(42'h3FF_0000_FFFF, 1'b0);
        end
        wait_idle("drop", 40);
        tests++;
        if (drop_cnt !== 8'd3) begin
            fails++;
            $display("FAIL drop_cnt: drop=%h required 03", drop_cnt);
        end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_ready = 1'b0;
        pulse(42'h0F0_F0F0_F0F0, 1'b1);
        data_in   = 42'h155_5555_5555;
        dvalid_in = 1'b1;
        repeat (254) @(posedge clk);
        #1;
        tests++;
        if (drop_cnt !== 8'hFE) begin
            fails++;
            $display("FAIL sat_254: drop=%h required FE", drop_cnt);
        end
        repeat (46) @(posedge clk);
        #1;
        dvalid_in = 1'b0;
        tests++;
        if (drop_cnt !== 8'hFF || tx_valid !== 1'b1 || tx_data !== HDR) begin
            fails++;
            $display("FAIL sat_300: drop=%h valid=%0b data=%h required FF/1/%h", drop_cnt, tx_valid, tx_data, HDR);
        end
        tx_ready = 1'b1;
        wait_idle("sat_drain", 40);
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b1;
        pulse(42'h2A5_5A5A_5A5A, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 6) begin
            fails++;
            $display("FAIL mid_progress: remaining=%0d required 6", exp_q.size());
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'h00 || tx_data !== 4'h0) begin
            fails++;
            $display("FAIL mid_reset: valid=%0b busy=%0b drop=%h data=%h required 0/0/00/0", tx_valid, busy, drop_cnt, tx_data);
        end
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (tx_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_hold: valid=%0b required 0", tx_valid);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse(42'h3C3_C3C3_C3C3, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests++;
            if (tx_valid !== 1'b1) begin
                fails++;
                $display("FAIL post_reset_cycle%0d: valid=%0b required 1", i, tx_valid);
            end
        end
        @(posedge clk); #1;
        wait_idle("post_reset", 20);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        fork
            monitor_beats();
        join_none
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_drop();
        test_saturation();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: remaining=%0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
